// File: rtl/he_pkg.sv
// he_pkg: shared defaults, word type and mode encodings for ciphertext arithmetic
package he_pkg;
    localparam int DEF_CIPHERTEXT_MODULUS = 1024;
    localparam int DEF_CIPHERTEXT_WIDTH = 10;
    localparam int DEF_DIMENSION = 4;
    typedef logic [DEF_CIPHERTEXT_WIDTH-1:0] ct_word_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/mod_addsub.sv
// mod_addsub: combinational W-bit modular add/subtract with operand range check
module mod_addsub import he_pkg::*; #(
    parameter int W = DEF_CIPHERTEXT_WIDTH,
    parameter int Q = DEF_CIPHERTEXT_MODULUS
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] y_o,
    output logic         oor_o
);
    localparam logic [W:0] QW = (W+1)'(Q);
    logic [W:0] s, d;
    assign s = {1'b0, a_i} + {1'b0, b_i};
    assign d = {1'b0, a_i} - {1'b0, b_i};
    assign y_o = sub_i == MODE_SUB ? (d[W] ? W'(d + QW) : d[W-1:0])
                                   : (s >= QW ? W'(s - QW) : s[W-1:0]);
    assign oor_o = {1'b0, a_i} >= QW || {1'b0, b_i} >= QW;
endmodule

// File: rtl/homomorphic_addsub_vec.sv
// homomorphic_addsub_vec: streaming element-serial LWE ciphertext add/subtract mod q
module homomorphic_addsub_vec import he_pkg::*; #(
    parameter int CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
    parameter int CIPHERTEXT_WIDTH = DEF_CIPHERTEXT_WIDTH,
    parameter int DIMENSION = DEF_DIMENSION,
    parameter int CNT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sub,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct1_word,
    input  logic [CIPHERTEXT_WIDTH-1:0] ct2_word,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CIPHERTEXT_WIDTH-1:0] out_word,
    output logic                        out_last,
    output logic                        range_err
);
    localparam int W = CIPHERTEXT_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DIMENSION);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [W-1:0] word_q, word_d, res;
    logic mode_q, mode_d, valid_q, valid_d, last_q, last_d, err_q, err_d;
    logic fire, sub, oor;
    assign in_ready = !valid_q || out_ready;
    assign fire = in_valid && in_ready;
    assign sub = cnt_q == '0 ? in_sub : mode_q;
    mod_addsub #(.W(W), .Q(CIPHERTEXT_MODULUS)) u_mod (
        .a_i(ct1_word), .b_i(ct2_word), .sub_i(sub), .y_o(res), .oor_o(oor)
    );
    always_comb begin
        cnt_d = fire ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        mode_d = fire && cnt_q == '0 ? in_sub : mode_q;
        valid_d = fire || (valid_q && !out_ready);
        word_d = fire ? res : word_q;
        last_d = fire ? cnt_q == LAST : last_q;
        err_d = err_q || (fire && oor);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            mode_q <= MODE_ADD;
            valid_q <= 1'b0;
            word_q <= '0;
            last_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            mode_q <= mode_d;
            valid_q <= valid_d;
            word_q <= word_d;
            last_q <= last_d;
            err_q <= err_d;
        end
    end
    assign out_valid = valid_q;
    assign out_word = word_q;
    assign out_last = last_q;
    assign range_err = err_q;
endmodule

// File: tb/tb_homomorphic_addsub_vec.sv
// tb_homomorphic_addsub_vec: model-checked bench driving a q=1024 and a q=1000 instance in lockstep
module tb_homomorphic_addsub_vec;
    import he_pkg::*;
    localparam int QA = 1024;
    localparam int QB = 1000;
    localparam int N = 4;
    typedef struct { int w; bit l; bit dc; } exp_t;
    typedef struct { ct_word_t wa; ct_word_t wb; bit la; int cyc; } rec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_sub = 1'b0;
    logic out_ready = 1'b1;
    ct_word_t ct1 = '0, ct2 = '0;
    logic in_ready_a, out_valid_a, out_last_a, range_err_a;
    logic in_ready_b, out_valid_b, out_last_b, range_err_b;
    ct_word_t out_word_a, out_word_b;
    int checks = 0, errors = 0, cyc = 0;
    bit started = 1'b0, pat_en = 1'b0;
    int pidx = 0;
    logic [3:0] pat = 4'b1001;
    exp_t qa[$], qb[$];
    rec_t log_q[$];
    int mcnt = 0;
    bit mmode = 1'b0, msub = 1'b0, err_a = 1'b0, err_b = 1'b0;

    homomorphic_addsub_vec #(.CIPHERTEXT_MODULUS(QA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_sub(in_sub),
        .ct1_word(ct1), .ct2_word(ct2), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_word(out_word_a), .out_last(out_last_a), .range_err(range_err_a)
    );
    homomorphic_addsub_vec #(.CIPHERTEXT_MODULUS(QB)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_sub(in_sub),
        .ct1_word(ct1), .ct2_word(ct2), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_word(out_word_b), .out_last(out_last_b), .range_err(range_err_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = pat_en ? pat[pidx] : 1'b1;
        pidx = pat_en ? (pidx + 1) % 4 : 0;
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input longint act, input longint exp);
        chk(act == exp, name, act, exp);
    endtask

    function automatic int em(int q, int a, int b, bit s);
        return s ? (a - b + q) % q : (a + b) % q;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk(out_valid_a == (qa.size() != 0), "valid_a", out_valid_a, qa.size() != 0);
            chk(out_valid_b == (qb.size() != 0), "valid_b", out_valid_b, qb.size() != 0);
            chk(in_ready_a == (!out_valid_a || out_ready), "ready_a", in_ready_a, !out_valid_a || out_ready);
            chk(in_ready_b == (!out_valid_b || out_ready), "ready_b", in_ready_b, !out_valid_b || out_ready);
            chk(range_err_a == err_a, "err_a", range_err_a, err_a);
            chk(range_err_b == err_b, "err_b", range_err_b, err_b);
            if (out_valid_a && qa.size() != 0) begin
                if (!qa[0].dc) chk(out_word_a == ct_word_t'(qa[0].w), "word_a", out_word_a, qa[0].w);
                chk(out_last_a == qa[0].l, "last_a", out_last_a, qa[0].l);
            end
            if (out_valid_b && qb.size() != 0) begin
                if (!qb[0].dc) chk(out_word_b == ct_word_t'(qb[0].w), "word_b", out_word_b, qb[0].w);
                chk(out_last_b == qb[0].l, "last_b", out_last_b, qb[0].l);
            end
            if (out_valid_a && out_ready && qa.size() != 0 && qb.size() != 0) begin
                log_q.push_back('{out_word_a, out_word_b, out_last_a, cyc});
                qa.delete(0);
                qb.delete(0);
            end
        end
        if (rst) begin
            qa.delete();
            qb.delete();
            mcnt = 0;
            mmode = 1'b0;
            err_a = 1'b0;
            err_b = 1'b0;
        end else if (started && in_valid && in_ready_a) begin
            msub = mcnt == 0 ? in_sub : mmode;
            if (mcnt == 0) mmode = in_sub;
            qa.push_back('{em(QA, int'(ct1), int'(ct2), msub), mcnt == N, int'(ct1) >= QA || int'(ct2) >= QA});
            qb.push_back('{em(QB, int'(ct1), int'(ct2), msub), mcnt == N, int'(ct1) >= QB || int'(ct2) >= QB});
            err_a = err_a || int'(ct1) >= QA || int'(ct2) >= QA;
            err_b = err_b || int'(ct1) >= QB || int'(ct2) >= QB;
            mcnt = mcnt == N ? 0 : mcnt + 1;
        end
    end

    task automatic send(input int a, input int b, input bit s);
        int i = 0;
        ct1 = ct_word_t'(a);
        ct2 = ct_word_t'(b);
        in_sub = s;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            i++;
        end while (!in_ready_a && i < 50);
        if (!in_ready_a) chk(1'b0, "send_timeout", i, 50);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send5(input int p[10], input bit s0, input bit sr);
        for (int k = 0; k < 5; k++) send(p[2*k], p[2*k+1], k == 0 ? s0 : sr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=%0d expected=0", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        lit("reset_valid", out_valid_a, 0);
        lit("reset_word", out_word_a, 0);
        lit("reset_last", out_last_a, 0);
        lit("reset_err", range_err_b, 0);
        lit("reset_ready", in_ready_a, 1);
        started = 1'b1;
        @(posedge clk);
        #1;
        send5('{999, 999, 0, 0, 5, 3, 1, 2, 998, 1}, 1'b0, 1'b0);
        send5('{0, 999, 10, 3, 3, 10, 0, 0, 999, 0}, 1'b1, 1'b1);
        idle(3);
        lit("err_b_clean", range_err_b, 0);
        send5('{1000, 1, 1, 1, 1, 1, 1, 1, 1, 1}, 1'b0, 1'b0);
        idle(3);
        lit("err_b_set", range_err_b, 1);
        lit("err_a_clear", range_err_a, 0);
        send5('{3, 5, 1000, 30, 512, 512, 0, 0, 1023, 1}, 1'b0, 1'b0);
        send5('{5, 3, 3, 5, 0, 1023, 7, 7, 100, 0}, 1'b1, 1'b0);
        idle(3);
        lit("err_b_sticky", range_err_b, 1);
        pat_en = 1'b1;
        send5('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}, 1'b0, 1'b0);
        pat_en = 1'b0;
        idle(4);
        send(1, 1, 1'b0);
        send(2, 2, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        lit("rst_mid_valid", out_valid_a, 0);
        lit("rst_mid_err", range_err_b, 0);
        @(posedge clk);
        #1;
        send5('{10, 20, 30, 40, 1, 1, 2, 2, 3, 3}, 1'b0, 1'b0);
        idle(3);
        for (int k = 0; k < 15; k++) send(k, k, 1'b0);
        idle(4);
        lit("log_count", log_q.size(), 52);
        if (log_q.size() == 52) begin
            lit("c1_w0_a", log_q[0].wa, 974);
            lit("c1_w0_b", log_q[0].wb, 998);
            lit("c1_last3", log_q[3].la, 0);
            lit("c1_last4", log_q[4].la, 1);
            lit("c2_w0_b", log_q[5].wb, 1);
            lit("c2_w0_a", log_q[5].wa, 25);
            lit("c2_w2_b", log_q[7].wb, 993);
            lit("t1_w0", log_q[15].wa, 8);
            lit("t1_w1", log_q[16].wa, 6);
            lit("t1_w2", log_q[17].wa, 0);
            lit("t1_w2_b", log_q[17].wb, 24);
            lit("t1_w3", log_q[18].wa, 0);
            lit("t1_w4", log_q[19].wa, 0);
            lit("t1_last1", log_q[16].la, 0);
            lit("t1_last4", log_q[19].la, 1);
            lit("t2_w0", log_q[20].wa, 2);
            lit("t2_w1", log_q[21].wa, 1022);
            lit("t2_w2", log_q[22].wa, 1);
            lit("t2_w3", log_q[23].wa, 0);
            lit("t2_w4", log_q[24].wa, 100);
            lit("stall_w0", log_q[25].wa, 3);
            lit("stall_w2", log_q[27].wa, 11);
            lit("stall_w4", log_q[29].wa, 19);
            lit("stall_last", log_q[29].la, 1);
            lit("rst_new_w0", log_q[32].wa, 30);
            lit("rst_new_last0", log_q[32].la, 0);
            lit("rst_new_w4", log_q[36].wa, 6);
            lit("rst_new_last4", log_q[36].la, 1);
            lit("b2b_span", log_q[51].cyc - log_q[37].cyc, 14);
            lit("b2b_last5", log_q[41].la, 1);
            lit("b2b_last4", log_q[40].la, 0);
            lit("b2b_last10", log_q[46].la, 1);
            lit("b2b_last15", log_q[51].la, 1);
            lit("b2b_w14", log_q[51].wa, 28);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
